// File: rtl/sobel_stream_core.sv
// sobel_stream_core
//   Streaming 3x3 Sobel engine over raster-order, channel-interleaved samples.
//   Two line buffers supply the two previous rows. Three shift rows form a
//   per-channel window. A 3-stage pipeline (window register, Gx/Gy,
//   abs/sum/saturate/mode) emits one result per fully-interior window.
//
// Ports
//   CLK, RST_N           clock (rising edge), asynchronous active-low reset
//   in_valid/in_sof      sample strobe (no backpressure) / first sample of frame
//   in_data [DW]         sample value
//   mode [2], thr [DW]   output function select and mode-3 threshold,
//                        both captured with each sample
//   out_valid            one-cycle pulse per result
//   out_data [DW]        result, held between pulses
//   out_sof, out_last    first / last result of the frame, qualified by out_valid
//   overflow             sticky: a sample arrived after the frame completed
module sobel_stream_core #(
    parameter int DW     = 8,
    parameter int LINE_W = 640,
    parameter int IMG_H  = 480,
    parameter int CH     = 3
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] thr,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_sof,
    output logic          out_last,
    output logic          overflow
);
    localparam int unsigned SN   = LINE_W * CH;
    localparam int unsigned SW   = (SN > 1) ? $clog2(SN) : 1;
    localparam int unsigned CW   = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int unsigned KW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned RW   = $clog2(IMG_H + 1);
    localparam int unsigned TAPS = 2 * CH + 1;
    localparam int unsigned GW   = DW + 4;

    // Raster counters: s = sample in line, c = column, k = channel, r = line.
    // c and k run alongside s so no divider is needed.
    logic [SW-1:0] s_q, s_e;
    logic [CW-1:0] c_q, c_e;
    logic [KW-1:0] k_q, k_e;
    logic [RW-1:0] r_q, r_e;
    logic          accept, win_ok;

    // in_sof overrides the counters for the sample it qualifies.
    always_comb begin
        s_e    = in_sof ? '0 : s_q;
        c_e    = in_sof ? '0 : c_q;
        k_e    = in_sof ? '0 : k_q;
        r_e    = in_sof ? '0 : r_q;
        accept = in_valid && (r_e < RW'(IMG_H));
        win_ok = accept && (r_e >= RW'(2)) && (c_e >= CW'(2));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s_q      <= '0;
            c_q      <= '0;
            k_q      <= '0;
            r_q      <= '0;
            overflow <= 1'b0;
        end else if (in_valid) begin
            if (accept) begin
                if (s_e == SW'(SN - 1)) begin
                    s_q <= '0;
                    r_q <= r_e + 1'b1;
                end else begin
                    s_q <= s_e + 1'b1;
                    r_q <= r_e;
                end
                if (k_e == KW'(CH - 1)) begin
                    k_q <= '0;
                    c_q <= (c_e == CW'(LINE_W - 1)) ? '0 : c_e + 1'b1;
                end else begin
                    k_q <= k_e + 1'b1;
                    c_q <= c_e;
                end
            end
            if (in_sof)
                overflow <= 1'b0;
            else if (!accept)
                overflow <= 1'b1;
        end
    end

    // Line buffers: LB0 holds row r-1, LB1 row r-2 (read-before-write).
    logic [DW-1:0] lb0 [SN];
    logic [DW-1:0] lb1 [SN];

    always_ff @(posedge CLK) begin
        if (accept) begin
            lb1[s_e] <= lb0[s_e];
            lb0[s_e] <= in_data;
        end
    end

    // Stage 1: window shift rows (index 0 = newest) plus frame flags.
    logic [DW-1:0] top_sr [TAPS];
    logic [DW-1:0] mid_sr [TAPS];
    logic [DW-1:0] bot_sr [TAPS];
    logic          v1, sof1, last1;
    logic [1:0]    mode1;
    logic [DW-1:0] thr1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                top_sr[i] <= '0;
                mid_sr[i] <= '0;
                bot_sr[i] <= '0;
            end
            v1    <= 1'b0;
            sof1  <= 1'b0;
            last1 <= 1'b0;
            mode1 <= '0;
            thr1  <= '0;
        end else begin
            v1    <= win_ok;
            sof1  <= win_ok && (r_e == RW'(2)) && (c_e == CW'(2)) && (k_e == '0);
            last1 <= win_ok && (r_e == RW'(IMG_H - 1)) && (c_e == CW'(LINE_W - 1))
                     && (k_e == KW'(CH - 1));
            if (accept) begin
                top_sr[0] <= lb1[s_e];
                mid_sr[0] <= lb0[s_e];
                bot_sr[0] <= in_data;
                for (int unsigned i = 1; i < TAPS; i++) begin
                    top_sr[i] <= top_sr[i-1];
                    mid_sr[i] <= mid_sr[i-1];
                    bot_sr[i] <= bot_sr[i-1];
                end
                mode1 <= mode;
                thr1  <= thr;
            end
        end
    end

    // Stage 2: gradients. Taps 0, CH, 2*CH are columns c, c-1, c-2.
    function automatic logic signed [GW-1:0] ext(input logic [DW-1:0] x);
        return $signed({4'b0000, x});
    endfunction

    logic signed [GW-1:0] gx_c, gy_c, gx_q, gy_q;
    logic                 v2, sof2, last2;
    logic [1:0]           mode2;
    logic [DW-1:0]        thr2;

    always_comb begin
        gx_c = (ext(top_sr[0]) + ext(mid_sr[0]) + ext(mid_sr[0]) + ext(bot_sr[0]))
             - (ext(top_sr[2*CH]) + ext(mid_sr[2*CH]) + ext(mid_sr[2*CH]) + ext(bot_sr[2*CH]));
        gy_c = (ext(bot_sr[2*CH]) + ext(bot_sr[CH]) + ext(bot_sr[CH]) + ext(bot_sr[0]))
             - (ext(top_sr[2*CH]) + ext(top_sr[CH]) + ext(top_sr[CH]) + ext(top_sr[0]));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gx_q  <= '0;
            gy_q  <= '0;
            v2    <= 1'b0;
            sof2  <= 1'b0;
            last2 <= 1'b0;
            mode2 <= '0;
            thr2  <= '0;
        end else begin
            v2    <= v1;
            sof2  <= sof1;
            last2 <= last1;
            if (v1) begin
                gx_q  <= gx_c;
                gy_q  <= gy_c;
                mode2 <= mode1;
                thr2  <= thr1;
            end
        end
    end

    // Stage 3: magnitude, saturation and output function.
    logic [GW-1:0] ax, ay, sum;
    logic [DW-1:0] res;

    function automatic logic [DW-1:0] sat(input logic [GW-1:0] x);
        return (x[GW-1:DW] != '0) ? '1 : x[DW-1:0];
    endfunction

    always_comb begin
        ax  = gx_q[GW-1] ? -gx_q : gx_q;
        ay  = gy_q[GW-1] ? -gy_q : gy_q;
        sum = ax + ay;
        res = '0;
        case (mode2)
            2'd0:    res = sat(sum);
            2'd1:    res = sat(ax);
            2'd2:    res = sat(ay);
            default: res = (sum >= {4'b0000, thr2}) ? '1 : '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= v2;
            out_sof   <= v2 && sof2;
            out_last  <= v2 && last2;
            if (v2)
                out_data <= res;
        end
    end
endmodule

// File: tb/tb_sobel_stream_core.sv
// Bench for sobel_stream_core: two instances on a 5x4 image, CH=1 and CH=2.
// Drivers push expected results into per-instance queues; monitors pop and
// compare whenever out_valid is seen.
module tb_sobel_stream_core;
    logic       CLK = 1'b0;
    logic       rst_n;
    logic       iv1, iv2, in_sof;
    logic [7:0] in_data, thr;
    logic [1:0] mode;

    logic       o1_valid, o1_sof, o1_last, o1_ovf;
    logic [7:0] o1_data;
    logic       o2_valid, o2_sof, o2_last, o2_ovf;
    logic [7:0] o2_data;

    always #5 CLK = ~CLK;

    sobel_stream_core #(.DW(8), .LINE_W(5), .IMG_H(4), .CH(1)) dut1 (
        .CLK(CLK), .RST_N(rst_n), .in_valid(iv1), .in_sof(in_sof),
        .in_data(in_data), .mode(mode), .thr(thr),
        .out_valid(o1_valid), .out_data(o1_data), .out_sof(o1_sof),
        .out_last(o1_last), .overflow(o1_ovf));

    sobel_stream_core #(.DW(8), .LINE_W(5), .IMG_H(4), .CH(2)) dut2 (
        .CLK(CLK), .RST_N(rst_n), .in_valid(iv2), .in_sof(in_sof),
        .in_data(in_data), .mode(mode), .thr(thr),
        .out_valid(o2_valid), .out_data(o2_data), .out_sof(o2_sof),
        .out_last(o2_last), .overflow(o2_ovf));

    typedef struct {
        logic [7:0] d;
        bit         sof;
        bit         last;
        int         cyc;
    } exp_t;

    exp_t       q1[$];
    exp_t       q2[$];
    int         n_pass  = 0;
    int         n_total = 0;
    int         cyc     = 0;
    logic [7:0] exp_d [12];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    exp_t e1, e2;

    always @(negedge CLK) begin
        if (o1_valid) begin
            if (q1.size() == 0) begin
                check("ch1 unexpected out_valid", 1, 0);
            end else begin
                e1 = q1.pop_front();
                check("ch1 out_data", o1_data, e1.d);
                check("ch1 out_sof", o1_sof, e1.sof);
                check("ch1 out_last", o1_last, e1.last);
                check("ch1 latency cycle", cyc, e1.cyc);
            end
        end
    end

    always @(negedge CLK) begin
        if (o2_valid) begin
            if (q2.size() == 0) begin
                check("ch2 unexpected out_valid", 1, 0);
            end else begin
                e2 = q2.pop_front();
                check("ch2 out_data", o2_data, e2.d);
                check("ch2 out_sof", o2_sof, e2.sof);
                check("ch2 out_last", o2_last, e2.last);
                check("ch2 latency cycle", cyc, e2.cyc);
            end
        end
    end

    // Image kinds: 0 constant 77, 1 vertical edge (cols 2-4 = 100),
    // 2 vertical ramp of 5 per row, 3 ch0 constant 50 / ch1 edge.
    function automatic logic [7:0] pix(input int img, input int r, input int c, input int k);
        case (img)
            0:       return 8'd77;
            1:       return (c >= 2) ? 8'd100 : 8'd0;
            2:       return 8'(r * 5);
            3:       return (k == 0) ? 8'd50 : ((c >= 2) ? 8'd100 : 8'd0);
            default: return 8'd0;
        endcase
    endfunction

    task automatic set_exp1(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        exp_d[0] = a; exp_d[1] = b; exp_d[2] = c;
        exp_d[3] = a; exp_d[4] = b; exp_d[5] = c;
    endtask

    // Drives n_samp samples from raster start; each sample is one cycle,
    // optionally preceded by 1..gap_max idle cycles.
    task automatic frame(input int ch, input int img, input logic [1:0] md,
                         input logic [7:0] th, input int gap_max, input int n_samp,
                         input bit expect_out, input bit use_sof);
        int   per_line;
        exp_t e;
        per_line = 5 * ch;
        for (int i = 0; i < n_samp; i++) begin
            int s, r, c, k, n;
            if (gap_max > 0 && i > 0) begin
                repeat ($urandom_range(1, gap_max)) @(posedge CLK);
                #1;
            end
            s = i % per_line;
            r = i / per_line;
            c = s / ch;
            k = s % ch;
            in_sof  = use_sof && (i == 0);
            in_data = pix(img, r, c, k);
            mode    = md;
            thr     = th;
            if (ch == 1) iv1 = 1'b1;
            else         iv2 = 1'b1;
            if (expect_out && r >= 2 && c >= 2) begin
                n      = ((r - 2) * 3 + (c - 2)) * ch + k;
                e.d    = exp_d[n];
                e.sof  = (n == 0);
                e.last = (n == 6 * ch - 1);
                e.cyc  = cyc + 3;
                if (ch == 1) q1.push_back(e);
                else         q2.push_back(e);
            end
            @(posedge CLK);
            #1;
            iv1    = 1'b0;
            iv2    = 1'b0;
            in_sof = 1'b0;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q1.size() != 0 || q2.size() != 0) && w < 40) begin
            @(posedge CLK);
            #1;
            w++;
        end
        check("results pending after drain", q1.size() + q2.size(), 0);
        repeat (4) @(posedge CLK);
        #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; iv1 = 1'b0; iv2 = 1'b0; in_sof = 1'b0;
        in_data = '0; mode = '0; thr = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset out_valid", o1_valid, 0);
        check("reset out_data", o1_data, 0);
        check("reset out_sof", o1_sof, 0);
        check("reset out_last", o1_last, 0);
        check("reset overflow", o1_ovf, 0);
        check("reset ch2 out_valid", o2_valid, 0);
        rst_n = 1'b1;
        @(posedge CLK);
        #1;

        set_exp1(8'd0, 8'd0, 8'd0);         frame(1, 0, 2'd0, 8'd0, 0, 20, 1, 1); drain();
        set_exp1(8'd255, 8'd255, 8'd0);     frame(1, 1, 2'd0, 8'd0, 0, 20, 1, 1); drain();
        set_exp1(8'd255, 8'd255, 8'd0);     frame(1, 1, 2'd1, 8'd0, 0, 20, 1, 1); drain();
        set_exp1(8'd0, 8'd0, 8'd0);         frame(1, 1, 2'd2, 8'd0, 0, 20, 1, 1); drain();

        // |Gy| = 4 * (row r - row r-2) = 4 * 10 = 40, Gx = 0.
        set_exp1(8'd40, 8'd40, 8'd40);      frame(1, 2, 2'd2, 8'd0, 0, 20, 1, 1); drain();
        check("out_data held between pulses", o1_data, 40);
        check("out_valid idle", o1_valid, 0);
        set_exp1(8'd255, 8'd255, 8'd255);   frame(1, 2, 2'd3, 8'd40, 0, 20, 1, 1); drain();
        set_exp1(8'd0, 8'd0, 8'd0);         frame(1, 2, 2'd3, 8'd41, 0, 20, 1, 1); drain();

        exp_d = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd0,
                  8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd0};
        frame(2, 3, 2'd0, 8'd0, 0, 40, 1, 1); drain();

        set_exp1(8'd255, 8'd255, 8'd0);     frame(1, 1, 2'd0, 8'd0, 7, 20, 1, 1); drain();

        // Extra sample after a complete frame, without in_sof.
        check("overflow before extra sample", o1_ovf, 0);
        frame(1, 1, 2'd0, 8'd0, 0, 1, 0, 0); drain();
        check("overflow after extra sample", o1_ovf, 1);
        set_exp1(8'd255, 8'd255, 8'd255);   frame(1, 2, 2'd3, 8'd40, 0, 20, 1, 1);
        check("overflow cleared by in_sof", o1_ovf, 0);
        drain();

        // Reset right after the sample completing the first window.
        frame(1, 1, 2'd0, 8'd0, 0, 13, 0, 1);
        rst_n = 1'b0;
        #1;
        check("mid-frame reset out_valid", o1_valid, 0);
        check("mid-frame reset out_data", o1_data, 0);
        check("mid-frame reset out_sof", o1_sof, 0);
        check("mid-frame reset out_last", o1_last, 0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        rst_n = 1'b1;
        frame(1, 1, 2'd0, 8'd0, 0, 5, 0, 0); drain();
        set_exp1(8'd255, 8'd255, 8'd0);     frame(1, 1, 2'd0, 8'd0, 0, 20, 1, 1); drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
